phase_timer_param: RTL and testbench

//  Parametrised traffic-light phase timer: prescales clk100M to a seconds tick and

---
 rtl/phase_timer_param_if.sv | 24 ++
 rtl/phase_timer_param.sv | 135 +++++++++++++
 tb/tb_phase_timer_param.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/phase_timer_param_if.sv
// Bus bundle for the traffic-light phase timer: start/hold controls in,
// phase, remaining count and expiry strobes out.
interface phase_timer_param_if #(
  parameter int CNT_W = 7
);
  logic             sc;
  logic             hold;
  logic             running;
  logic [1:0]       phase;
  logic [CNT_W-1:0] count_o;
  logic             phase_done;
  logic             t_long;
  logic             t_short;

  modport master (
    output sc, hold,
    input  running, phase, count_o, phase_done, t_long, t_short
  );

  modport slave (
    input  sc, hold,
    output running, phase, count_o, phase_done, t_long, t_short
  );
endinterface

// File: rtl/phase_timer_param.sv
// Four-phase traffic-light timer: prescales the clock to a count tick and
// sequences NS green/yellow, EW green/yellow with per-phase durations.
module phase_timer_param #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 7,
  parameter int T_G_NS  = 30,
  parameter int T_Y_NS  = 3,
  parameter int T_G_EW  = 30,
  parameter int T_Y_EW  = 3
) (
  input  logic                clk100M,
  input  logic                rst,
  phase_timer_param_if.slave  bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic             sc_q_r;
  logic [PRE_W-1:0] presc_r, presc_s;
  logic [1:0]       phase_r, phase_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             running_r, running_s;
  logic             done_r, done_s;
  logic             long_r, long_s;
  logic             short_r, short_s;
  logic             start_s;
  logic             tick_s;

  // Duration in ticks of a given phase.
  function automatic logic [CNT_W-1:0] phase_dur(input logic [1:0] ph);
    logic [CNT_W-1:0] d;
    case (ph)
      2'd0:    d = CNT_W'(T_G_NS);
      2'd1:    d = CNT_W'(T_Y_NS);
      2'd2:    d = CNT_W'(T_G_EW);
      2'd3:    d = CNT_W'(T_Y_EW);
      default: d = CNT_W'(T_G_NS);
    endcase
    return d;
  endfunction

  // State, timing and strobe registers.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      sc_q_r    <= 1'b0;
      presc_r   <= '0;
      phase_r   <= 2'd0;
      count_r   <= '0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
      long_r    <= 1'b0;
      short_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      sc_q_r    <= bus.sc;
      presc_r   <= presc_s;
      phase_r   <= phase_s;
      count_r   <= count_s;
      running_r <= running_s;
      done_r    <= done_s;
      long_r    <= long_s;
      short_r   <= short_s;
    end
  end

  // Next-state logic; a start request wins over tick and hold.
  always_comb begin
    start_s   = bus.sc & ~sc_q_r;
    tick_s    = (state_r == RUN) && !bus.hold && (presc_r == PRE_LAST);
    state_s   = state_r;
    presc_s   = presc_r;
    phase_s   = phase_r;
    count_s   = count_r;
    done_s    = 1'b0;
    long_s    = 1'b0;
    short_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = RUN;
          presc_s = '0;
          phase_s = 2'd0;
          count_s = phase_dur(2'd0);
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (start_s) begin
          presc_s = '0;
          phase_s = 2'd0;
          count_s = phase_dur(2'd0);
        end else if (bus.hold) begin
          presc_s = presc_r;
        end else if (tick_s) begin
          presc_s = '0;
          if (count_r > CNT_W'(1)) begin
            count_s = count_r - CNT_W'(1);
          end else begin
            // Green phases are even, yellow phases odd.
            phase_s = phase_r + 2'd1;
            count_s = phase_dur(phase_r + 2'd1);
            done_s  = 1'b1;
            long_s  = ~phase_r[0];
            short_s = phase_r[0];
          end
        end else begin
          presc_s = presc_r + PRE_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    running_s = (state_s == RUN);
  end

  assign bus.running    = running_r;
  assign bus.phase      = phase_r;
  assign bus.count_o    = count_r;
  assign bus.phase_done = done_r;
  assign bus.t_long     = long_r;
  assign bus.t_short    = short_r;

endmodule

// File: tb/tb_phase_timer_param.sv
// Bench for phase_timer_param: an elapsed-cycle reference feeds a scoreboard
// that is compared every cycle, plus directed checks of the key scenarios.
module tb_phase_timer_param;
  localparam int CNT_W = 7;
  localparam int DIVB  = 10;
  localparam int PERIOD = DIVB * (5 + 2 + 5 + 2);

  typedef struct {
    logic             run;
    logic [1:0]       ph;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             tl;
    logic             ts;
  } exp_t;

  logic clk100M = 1'b0;
  logic rst     = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  exp_t sb_q[$];

  logic m_run = 1'b0;
  logic m_scq = 1'b0;
  logic m_inc = 1'b0;
  int   m_e   = 0;

  always #5 clk100M = ~clk100M;

  phase_timer_param_if #(.CNT_W(CNT_W)) bus ();

  phase_timer_param #(
    .CLK_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W),
    .T_G_NS(5), .T_Y_NS(2), .T_G_EW(5), .T_Y_EW(2)
  ) dut (
    .clk100M(clk100M),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs derived from active cycles elapsed since the last start.
  function automatic exp_t expect_now();
    exp_t x;
    int p, base, dur, ph;
    x = '{run: 1'b0, ph: 2'd0, cnt: '0, done: 1'b0, tl: 1'b0, ts: 1'b0};
    if (m_run) begin
      p = m_e % PERIOD;
      if (p < 50)       begin ph = 0; base = 0;   dur = 5; end
      else if (p < 70)  begin ph = 1; base = 50;  dur = 2; end
      else if (p < 120) begin ph = 2; base = 70;  dur = 5; end
      else              begin ph = 3; base = 120; dur = 2; end
      x.run  = 1'b1;
      x.ph   = 2'(ph);
      x.cnt  = CNT_W'(dur - (p - base) / DIVB);
      x.done = m_inc && (p == base);
      x.tl   = x.done && (ph % 2 == 1);
      x.ts   = x.done && (ph % 2 == 0);
    end
    return x;
  endfunction

  initial begin : model_p
    logic st;
    forever begin
      @(posedge clk100M or negedge rst);
      if (!rst) begin
        m_run = 1'b0; m_scq = 1'b0; m_e = 0; m_inc = 1'b0;
        sb_q.delete();
      end else begin
        st    = bus.sc & ~m_scq;
        m_scq = bus.sc;
        m_inc = 1'b0;
        if (st) begin
          m_run = 1'b1; m_e = 0;
        end else if (m_run && !bus.hold) begin
          m_e++; m_inc = 1'b1;
        end
        sb_q.push_back(expect_now());
      end
    end
  end

  initial begin : monitor_p
    exp_t x;
    forever begin
      @(negedge clk100M);
      if (rst && sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check_val("sb_running", bus.running,    x.run);
        check_val("sb_phase",   bus.phase,      x.ph);
        check_val("sb_count",   bus.count_o,    x.cnt);
        check_val("sb_done",    bus.phase_done, x.done);
        check_val("sb_t_long",  bus.t_long,     x.tl);
        check_val("sb_t_short", bus.t_short,    x.ts);
      end
    end
  end

  task automatic pulse_sc();
    @(posedge clk100M); #1 bus.sc = 1'b1;
    @(posedge clk100M); #1 bus.sc = 1'b0;
  endtask

  task automatic wait_e(input int target);
    for (int i = 0; i < 400; i++) begin
      if (m_e == target) break;
      @(posedge clk100M); #1;
    end
    check_val("wait_e", m_e, target);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_running"}, bus.running,    0);
    check_val({tag, "_phase"},   bus.phase,      0);
    check_val({tag, "_count"},   bus.count_o,    0);
    check_val({tag, "_done"},    bus.phase_done, 0);
    check_val({tag, "_t_long"},  bus.t_long,     0);
    check_val({tag, "_t_short"}, bus.t_short,    0);
  endtask

  initial begin : stim_p
    int  edges;
    bit  seen;
    bus.sc   = 1'b0;
    bus.hold = 1'b0;

    // Reset held for 50 cycles.
    repeat (50) @(posedge clk100M);
    #1 check_idle("reset");
    rst = 1'b1;

    // Long sc level: single start, count 5 then 4 after one tick period.
    @(posedge clk100M); #1 bus.sc = 1'b1;
    @(posedge clk100M); #1;
    check_val("start_running", bus.running, 1);
    check_val("start_count",   bus.count_o, 5);
    repeat (9) @(posedge clk100M);
    #1 bus.sc = 1'b0;
    @(posedge clk100M); #1;
    check_val("first_tick_count", bus.count_o, 4);

    // Full four-phase cycle, checked by the scoreboard.
    repeat (140) @(posedge clk100M);

    // Hold for 37 cycles mid phase 0 at count 3.
    pulse_sc();
    repeat (25) @(posedge clk100M);
    #1 bus.hold = 1'b1;
    repeat (20) @(posedge clk100M);
    #1 check_val("hold_count", bus.count_o, 3);
    repeat (17) @(posedge clk100M);
    #1 bus.hold = 1'b0;
    edges = 62;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk100M); edges++;
      @(negedge clk100M); seen = bus.phase_done;
    end
    check_val("hold_phase_len", edges, 87);

    // Restart exactly on the tick that would end phase 2.
    wait_e(119);
    bus.sc = 1'b1;
    @(posedge clk100M); #1 bus.sc = 1'b0;
    check_val("restart_phase",  bus.phase,      0);
    check_val("restart_count",  bus.count_o,    5);
    check_val("restart_done",   bus.phase_done, 0);
    check_val("restart_t_long", bus.t_long,     0);

    // Asynchronous reset between edges during phase 1.
    wait_e(55);
    check_val("pre_rst_phase", bus.phase, 1);
    @(posedge clk100M); #3 rst = 1'b0;
    #1 check_idle("async_rst");
    repeat (3) @(posedge clk100M);
    #1 rst = 1'b1;
    repeat (30) @(posedge clk100M);
    #1 check_val("post_rst_idle", bus.running, 0);
    pulse_sc();
    repeat (20) @(posedge clk100M);
    #1 check_val("post_rst_count", bus.count_o, 3);
    check_val("post_rst_running", bus.running, 1);

    @(posedge clk100M); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
